imem_loader: RTL

Instruction-memory responder for the fetch stage.
- Serves the 15-bit word address driven by fetch with 32-bit instruction words.
- Contains a byte-serial boot loader that fills the memory from an external byte source before the core runs.
- Sits between the fetch stage (address in, data out, `run` used as fetch enable) and the board-level byte link (UART RX or test host).

---
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: instruction memory for the fetch stage with a byte-serial boot loader.
//
// Load stream: 16-bit big-endian word count N, then N big-endian 32-bit words.
// Optional feature macro IMEM_LOAD_CSUM_EN: a trailing 8-bit checksum byte
// (sum mod 256 of all payload bytes) must match before the memory goes to RUN.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous reset, active-low
//   fetchaddr   word address from fetch
//   data        instruction word to fetch, one cycle after the address
//   run         memory valid, drives fetch enable
//   load_start  one-cycle request to begin a load (honoured in IDLE or RUN)
//   load_byte   loader byte
//   load_valid  load_byte valid
//   load_ready  loader accepts a byte this cycle
//   load_done   one-cycle pulse on the first RUN cycle after a successful load
//   load_err    sticky error: overflow past DEPTH or checksum mismatch
module imem_loader #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 1024,
    parameter bit          BOOT_RUN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetchaddr,
    output logic [DATA_W-1:0] data,
    output logic              run,
    input  logic              load_start,
    input  logic [7:0]        load_byte,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SR_W  = DATA_W - 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR0    = 3'd1,
        S_HDR1    = 3'd2,
        S_PAYLOAD = 3'd3
`ifdef IMEM_LOAD_CSUM_EN
        , S_CSUM  = 3'd4
`endif
        , S_RUN   = 3'd5
    } state_t;

`ifdef IMEM_LOAD_CSUM_EN
    localparam state_t S_END = S_CSUM;
`else
    localparam state_t S_END = S_RUN;
`endif

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  idx;
    logic [1:0]        bcnt;
    logic [SR_W-1:0]   word_sr;
`ifdef IMEM_LOAD_CSUM_EN
    logic [7:0]        csum;
`endif
    logic [DATA_W-1:0] mem [DEPTH];

    logic accept;
    logic word_done;
    logic word_last;
    logic idx_in_range;
    logic rd_in_range;
    logic restart;
    logic wr_en;

    // Loader byte acceptance is limited to the header/payload/checksum states.
    function automatic logic is_load_state(input state_t s);
        logic r;
        r = (s == S_HDR0) || (s == S_HDR1) || (s == S_PAYLOAD);
`ifdef IMEM_LOAD_CSUM_EN
        r = r || (s == S_CSUM);
`endif
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= BOOT_RUN ? S_RUN : S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (load_start) state_next = S_HDR0;
            S_HDR0:    if (accept) state_next = S_HDR1;
            S_HDR1:    if (accept) state_next = ({count[15:8], load_byte} == 16'd0) ? S_END : S_PAYLOAD;
            S_PAYLOAD: if (accept && word_last) state_next = S_END;
`ifdef IMEM_LOAD_CSUM_EN
            S_CSUM:    if (accept) state_next = (load_byte == csum) ? S_RUN : S_IDLE;
`endif
            S_RUN:     if (load_start) state_next = S_HDR0;
            default:   state_next = S_IDLE;
        endcase
    end

    // Handshake and datapath decode
    always_comb begin
        accept       = load_valid && load_ready;
        word_done    = accept && (state == S_PAYLOAD) && (bcnt == 2'd3);
        word_last    = (bcnt == 2'd3) && (idx == count - 16'd1);
        idx_in_range = 32'(idx) < DEPTH;
        rd_in_range  = 32'(fetchaddr) < DEPTH;
        restart      = load_start && ((state == S_IDLE) || (state == S_RUN));
        wr_en        = rst && word_done && idx_in_range;
    end

    // Registered outputs, counters and word assembly
    always_ff @(posedge clk) begin
        if (!rst) begin
            data       <= '0;
            run        <= BOOT_RUN;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            count      <= '0;
            idx        <= '0;
            bcnt       <= '0;
            word_sr    <= '0;
`ifdef IMEM_LOAD_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            data       <= ((state == S_RUN) && rd_in_range) ? mem[fetchaddr[IDX_W-1:0]] : '0;
            run        <= (state_next == S_RUN);
            load_ready <= is_load_state(state_next);
            // RUN is only reachable from load states outside of reset
            load_done  <= (state != S_RUN) && (state_next == S_RUN);

            if (restart) begin
                load_err <= 1'b0;
                count    <= '0;
                idx      <= '0;
                bcnt     <= '0;
`ifdef IMEM_LOAD_CSUM_EN
                csum     <= '0;
`endif
            end

            if (accept && (state == S_HDR0)) count[15:8] <= load_byte;
            if (accept && (state == S_HDR1)) count[7:0]  <= load_byte;

            if (accept && (state == S_PAYLOAD)) begin
                bcnt    <= bcnt + 2'd1;
                word_sr <= {word_sr[SR_W-9:0], load_byte};
`ifdef IMEM_LOAD_CSUM_EN
                csum    <= csum + load_byte;
`endif
            end

            // Out-of-range words are consumed but flagged
            if (word_done) begin
                idx <= idx + 16'd1;
                if (!idx_in_range) load_err <= 1'b1;
            end

`ifdef IMEM_LOAD_CSUM_EN
            if (accept && (state == S_CSUM) && (load_byte != csum)) load_err <= 1'b1;
`endif
        end
    end

    // Memory array: never reset, written on the 4th byte of each in-range word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx[IDX_W-1:0]] <= {word_sr, load_byte};
        end
    end

endmodule
